// File: rtl/imem_load_ctrl_if.sv
// Bundle of loader, IF-stage and memory-port signals of the instruction-memory controller.
// The slave modport is the controller's view; master is the surrounding system.
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              reload;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic              if_fault;
    logic              if_stall;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              ld_trunc;

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, if_req, if_addr, mem_rdata,
        output ld_ready, if_valid, if_instr, if_fault, if_stall,
               mem_we, mem_addr, mem_wdata, ld_trunc
    );

    modport master (
        output ld_valid, ld_data, ld_last, reload, if_req, if_addr, mem_rdata,
        input  ld_ready, if_valid, if_instr, if_fault, if_stall,
               mem_we, mem_addr, mem_wdata, ld_trunc
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Owner of the single instruction-memory port: zero-clears it after reset, streams in a
// program from the loader, then serves registered 1-cycle fetches to the IF stage.
module imem_load_ctrl #(
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    imem_load_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam state_e            RESET_STATE = CLEAR_EN ? ST_CLEAR : ST_LOAD;
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic              if_fault_q, if_fault_d;
    logic              ld_trunc_q, ld_trunc_d;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [31:0]       mem_wdata_c;
    logic              ld_ready_c;
    logic              addr_fault;

    // Misaligned PC or any set bit above the memory's byte range
    assign addr_fault = (bus.if_addr[1:0] != 2'b00) || (bus.if_addr[31:ADDR_W+2] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            clr_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_fault_q <= 1'b0;
            ld_trunc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_fault_q <= if_fault_d;
            ld_trunc_q <= ld_trunc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if_valid_d  = 1'b0;
        if_instr_d  = if_instr_q;
        if_fault_d  = 1'b0;
        ld_trunc_d  = ld_trunc_q;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        ld_ready_c  = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we_c   = 1'b1;
                mem_addr_c = clr_ptr_q;
                clr_ptr_d  = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end
            end

            ST_LOAD: begin
                ld_ready_c  = 1'b1;
                mem_addr_c  = wr_ptr_q;
                mem_wdata_c = bus.ld_data;
                if (bus.ld_valid) begin
                    mem_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (bus.ld_last) begin
                        state_d = ST_RUN;
                    end else if (wr_ptr_q == LAST_IDX) begin
                        // Memory full before the loader flagged its last word
                        state_d    = ST_RUN;
                        ld_trunc_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                mem_addr_c = bus.if_addr[ADDR_W+1:2];
                if (bus.reload) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end else if (bus.if_req) begin
                    if_valid_d = 1'b1;
                    if_fault_d = addr_fault;
                    if_instr_d = addr_fault ? 32'h0000_0000 : bus.mem_rdata;
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Write strobe and loader handshake stay quiet while reset is held
    assign bus.mem_we    = mem_we_c & ~rst;
    assign bus.ld_ready  = ld_ready_c & ~rst;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_fault  = if_fault_q;
    assign bus.if_stall  = (state_q != ST_RUN);
    assign bus.ld_trunc  = ld_trunc_q;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized bench for imem_load_ctrl: the bench owns the memory array and keeps a
// reference image of what the memory must contain, then checks every fetch against it.
module tb_imem_load_ctrl;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    imem_load_ctrl #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .CLEAR_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Physical memory: async read, write on posedge; prefilled with garbage before boot
    logic [31:0]       mem_array [DEPTH];
    logic              fill_en = 1'b0;
    logic [ADDR_W-1:0] fill_idx = '0;
    logic [31:0]       fill_val = '0;

    always @(posedge clk) begin
        if (bus.mem_we)
            mem_array[bus.mem_addr] <= bus.mem_wdata;
        else if (fill_en)
            mem_array[fill_idx] <= fill_val;
    end
    assign bus.mem_rdata = mem_array[bus.mem_addr];

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          ref_wr;
    bit          exp_trunc;
    logic [31:0] fixed_words [$];
    logic [31:0] fetch_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic void exp_fetch(input logic [31:0] a, output logic f, output logic [31:0] w);
        f = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        w = f ? 32'h0 : ref_mem[a[ADDR_W+1:2]];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            1:       a = $urandom | 32'h0000_1000;
            2, 3, 4: a = 32'($urandom_range(0, 40)) << 2;
            default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
        return a;
    endfunction

    // Counts clear cycles after reset release; expects DEPTH writes of zero to 0..DEPTH-1
    task automatic do_clear();
        int n   = 0;
        int bad = 0;
        for (int g = 0; g < 2000; g++) begin
            #1;
            if (!bus.mem_we) break;
            if (bus.mem_addr != ADDR_W'(n) || bus.mem_wdata != 32'h0 || !bus.if_stall || bus.ld_ready)
                bad++;
            n++;
            @(negedge clk);
        end
        check_val("clear_cycles", 32'(n), 32'(DEPTH));
        check_val("clear_bad_cycles", 32'(bad), 32'd0);
        check_val("ready_after_clear", 32'(bus.ld_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        ref_wr = 0;
        $display("clear done: %0d cycles", n);
    endtask

    // Streams up to n words; stops early when the model says the controller left LOAD
    task automatic load_prog(input int n, input bit with_last, input bit alt);
        int sent = 0;
        int cyc  = 0;
        bit done = 1'b0;
        bit v;
        while (!done && sent < n && cyc < 6000) begin
            v = alt ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            bus.ld_valid = v;
            bus.ld_data  = (fixed_words.size() > 0) ? fixed_words[0] : $urandom;
            bus.ld_last  = with_last && (sent == n - 1);
            #1;
            if (v) begin
                check_val("ld_ready", 32'(bus.ld_ready), 32'd1);
                check_val("ld_we", 32'(bus.mem_we), 32'd1);
                check_val("ld_addr", 32'(bus.mem_addr), 32'(ref_wr));
                check_val("ld_wdata", bus.mem_wdata, bus.ld_data);
                ref_mem[ref_wr] = bus.ld_data;
                if (fixed_words.size() > 0) void'(fixed_words.pop_front());
                if (bus.ld_last) begin
                    done = 1'b1;
                end else if (ref_wr == DEPTH - 1) begin
                    done      = 1'b1;
                    exp_trunc = 1'b1;
                end
                ref_wr++;
                sent++;
            end else begin
                check_val("ld_idle_we", 32'(bus.mem_we), 32'd0);
            end
            cyc++;
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        if (cyc >= 6000) check_val("load_timeout", 32'(cyc), 32'd0);
        check_val("stall_after_load", 32'(bus.if_stall), done ? 32'd0 : 32'd1);
        check_val("ld_trunc", 32'(bus.ld_trunc), 32'(exp_trunc));
        $display("load: %0d words accepted, done=%0d trunc=%0d", sent, done, exp_trunc);
    endtask

    // Issues fetch_q back-to-back and checks each response one cycle later
    task automatic fetch_seq();
        logic        f;
        logic [31:0] w;
        logic [31:0] last_w = bus.if_instr;
        for (int i = 0; i < fetch_q.size(); i++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = fetch_q[i];
            @(negedge clk);
            exp_fetch(fetch_q[i], f, w);
            check_val("fetch_valid", 32'(bus.if_valid), 32'd1);
            check_val("fetch_fault", 32'(bus.if_fault), 32'(f));
            check_val("fetch_instr", bus.if_instr, w);
            $display("fetch addr=%08h instr=%08h fault=%0d", fetch_q[i], bus.if_instr, bus.if_fault);
            last_w = w;
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        check_val("idle_valid", 32'(bus.if_valid), 32'd0);
        check_val("idle_fault", 32'(bus.if_fault), 32'd0);
        check_val("idle_hold_instr", bus.if_instr, last_w);
        fetch_q.delete();
    endtask

    task automatic fetch_random(input int n);
        for (int i = 0; i < n; i++) fetch_q.push_back(rand_addr());
        fetch_seq();
    endtask

    task automatic pulse_reload(input bit with_req);
        bus.reload  = 1'b1;
        bus.if_req  = with_req;
        bus.if_addr = 32'h4;
        @(negedge clk);
        bus.reload = 1'b0;
        bus.if_req = 1'b0;
        check_val("reload_valid", 32'(bus.if_valid), 32'd0);
        check_val("reload_stall", 32'(bus.if_stall), 32'd1);
        check_val("reload_ready", 32'(bus.ld_ready), 32'd1);
        ref_wr = 0;
        $display("reload (if_req=%0d)", with_req);
    endtask

    initial begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        bus.reload   = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        exp_trunc    = 1'b0;
        ref_wr       = 0;

        // Garbage prefill while reset is held, so the clear pass is observable
        fill_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fill_idx = ADDR_W'(i);
            fill_val = $urandom | 32'h1;
            @(negedge clk);
        end
        fill_en = 1'b0;

        check_val("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check_val("rst_if_instr", bus.if_instr, 32'h0);
        check_val("rst_if_fault", 32'(bus.if_fault), 32'd0);
        check_val("rst_ld_trunc", 32'(bus.ld_trunc), 32'd0);
        check_val("rst_if_stall", 32'(bus.if_stall), 32'd1);

        // T1: one-cycle reset then the clear pass
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_clear();

        // if_req during LOAD is ignored
        bus.if_req = 1'b1;
        @(negedge clk);
        bus.if_req = 1'b0;
        check_val("load_req_ignored", 32'(bus.if_valid), 32'd0);

        // T2: three-word program, loader valid every other cycle
        fixed_words = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020};
        load_prog(3, 1'b1, 1'b1);

        // ld_valid in RUN is ignored
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hDEAD_BEEF;
        #1;
        check_val("run_ld_ready", 32'(bus.ld_ready), 32'd0);
        check_val("run_ld_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        bus.ld_valid = 1'b0;

        // T3 and T4: directed fetches then random ones (cleared region must read 0)
        fetch_q = '{32'h0, 32'h4, 32'h8};
        fetch_seq();
        fetch_q = '{32'h2, 32'h1000, 32'hC, 32'h0FFC};
        fetch_seq();
        fetch_random(30);

        // T5: overlong stream without ld_last
        pulse_reload(1'b0);
        load_prog(DEPTH + 1, 1'b0, 1'b0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hCAFE_F00D;
        #1;
        check_val("extra_word_ready", 32'(bus.ld_ready), 32'd0);
        check_val("extra_word_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        fetch_random(40);

        // T6: reload beats a simultaneous fetch; short reload keeps older words above it
        pulse_reload(1'b1);
        load_prog($urandom_range(1, 20), 1'b1, 1'b0);
        fetch_random(40);

        // Reset in the middle of a load restarts the clear at index 0
        pulse_reload(1'b0);
        load_prog(5, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        exp_trunc = 1'b0;
        do_clear();
        check_val("trunc_cleared_by_rst", 32'(bus.ld_trunc), 32'd0);
        load_prog($urandom_range(1, 30), 1'b1, 1'b0);
        fetch_random(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
